id_ex_stage: RTL



---
 rtl/id_ex_pkg.sv | 58 +++++
 rtl/id_ex_stage_fwd_mux.sv | 35 +++
 rtl/id_ex_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pkg.sv
// ============================================================================
// Module   : id_ex_pkg
// Brief    : Shared opcode/funct codes, ALU select encoding and ID/EX fields
// Revision : 1.0
// ============================================================================
`default_nettype none

package id_ex_pkg;

  localparam int c_dw_default = 32;
  localparam int c_rw_default = 5;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_addiu = 6'h09;
  localparam logic [5:0] c_op_slti  = 6'h0A;
  localparam logic [5:0] c_op_andi  = 6'h0C;
  localparam logic [5:0] c_op_ori   = 6'h0D;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  localparam logic [5:0] c_fn_sll  = 6'h00;
  localparam logic [5:0] c_fn_srl  = 6'h02;
  localparam logic [5:0] c_fn_add  = 6'h20;
  localparam logic [5:0] c_fn_addu = 6'h21;
  localparam logic [5:0] c_fn_sub  = 6'h22;
  localparam logic [5:0] c_fn_subu = 6'h23;
  localparam logic [5:0] c_fn_and  = 6'h24;
  localparam logic [5:0] c_fn_or   = 6'h25;
  localparam logic [5:0] c_fn_slt  = 6'h2A;

  localparam logic [3:0] c_alu_add = 4'd0;
  localparam logic [3:0] c_alu_sub = 4'd1;
  localparam logic [3:0] c_alu_and = 4'd2;
  localparam logic [3:0] c_alu_or  = 4'd3;
  localparam logic [3:0] c_alu_lt  = 4'd5;
  localparam logic [3:0] c_alu_eq  = 4'd7;
  localparam logic [3:0] c_alu_shl = 4'd10;
  localparam logic [3:0] c_alu_shr = 4'd11;

  typedef enum logic [1:0] {A_ZERO = 2'd0, A_RS = 2'd1, A_RT = 2'd2} a_sel_t;
  typedef enum logic [1:0] {B_ZERO = 2'd0, B_RT = 2'd1, B_IMM = 2'd2} b_sel_t;

  // Operand values live outside this record so that they can be refreshed.
  typedef struct packed {
    logic [3:0] alu_s;
    a_sel_t     a_sel;
    b_sel_t     b_sel;
    logic       store_en;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
// ============================================================================
// Module   : fwd_mux
// Brief    : EX/MEM > MEM/WB > register-file priority operand select
// Revision : 1.0
// ============================================================================
`default_nettype none

module fwd_mux
  import id_ex_pkg::*;
#(
  parameter int DW = c_dw_default,
  parameter int RW = c_rw_default
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] rf_data,
  input  logic          exmem_wr,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_wr,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] data
);

  always_comb begin
    data = rf_data;
    if (idx != '0) begin
      if (exmem_wr && (exmem_rd == idx)) data = exmem_data;
      else if (memwb_wr && (memwb_rd == idx)) data = memwb_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register: decode to ALU select, forwarding, handshake
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DW = c_dw_default,
  parameter int RW = c_rw_default
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_opcode,
  input  logic [5:0]    in_funct,
  input  logic [4:0]    in_shamt,
  input  logic [15:0]   in_imm,
  input  logic [RW-1:0] in_rs,
  input  logic [RW-1:0] in_rt,
  input  logic [RW-1:0] in_rd,
  input  logic [DW-1:0] in_rs_data,
  input  logic [DW-1:0] in_rt_data,
  input  logic          exmem_wr,
  input  logic          memwb_wr,
  input  logic [RW-1:0] exmem_rd,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] exmem_data,
  input  logic [DW-1:0] memwb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    alu_s,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] out_store_data,
  output logic [RW-1:0] out_dst,
  output logic          out_reg_write,
  output logic          out_illegal
);

  logic          r_valid;
  ctrl_t         r_ctrl;
  logic [RW-1:0] r_rs, r_rt, r_dst;
  logic [DW-1:0] r_rs_val, r_rt_val, r_imm;

  logic          w_capture, w_hold;
  ctrl_t         w_ctrl;
  logic [RW-1:0] w_dst, w_rs_idx, w_rt_idx;
  logic [DW-1:0] w_imm, w_rs_base, w_rt_base, w_rs_fwd, w_rt_fwd;

  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;
  assign w_hold    = r_valid && !out_ready;

  // At capture forward into the incoming operands; while stalled, re-forward the held ones.
  assign w_rs_idx  = w_capture ? in_rs      : r_rs;
  assign w_rt_idx  = w_capture ? in_rt      : r_rt;
  assign w_rs_base = w_capture ? in_rs_data : r_rs_val;
  assign w_rt_base = w_capture ? in_rt_data : r_rt_val;

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .idx(w_rs_idx), .rf_data(w_rs_base),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .data(w_rs_fwd)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .idx(w_rt_idx), .rf_data(w_rt_base),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .data(w_rt_fwd)
  );

  always_comb begin
    w_ctrl = '{alu_s: c_alu_add, a_sel: A_ZERO, b_sel: B_ZERO,
               store_en: 1'b0, reg_write: 1'b0, illegal: 1'b0};
    w_dst  = '0;
    w_imm  = {{(DW-16){in_imm[15]}}, in_imm};
    unique case (in_opcode)
      c_op_rtype: begin
        w_ctrl.a_sel     = A_RS;
        w_ctrl.b_sel     = B_RT;
        w_ctrl.reg_write = 1'b1;
        w_dst            = in_rd;
        unique case (in_funct)
          c_fn_add, c_fn_addu: w_ctrl.alu_s = c_alu_add;
          c_fn_sub, c_fn_subu: w_ctrl.alu_s = c_alu_sub;
          c_fn_and:            w_ctrl.alu_s = c_alu_and;
          c_fn_or:             w_ctrl.alu_s = c_alu_or;
          c_fn_slt:            w_ctrl.alu_s = c_alu_lt;
          c_fn_sll, c_fn_srl: begin
            w_ctrl.alu_s = (in_funct == c_fn_sll) ? c_alu_shl : c_alu_shr;
            w_ctrl.a_sel = A_RT;
            w_ctrl.b_sel = B_IMM;
            w_imm        = {{(DW-5){1'b0}}, in_shamt};
          end
          default: begin
            w_ctrl = '{alu_s: c_alu_add, a_sel: A_ZERO, b_sel: B_ZERO,
                       store_en: 1'b0, reg_write: 1'b0, illegal: 1'b1};
            w_dst  = '0;
          end
        endcase
      end
      c_op_addi, c_op_addiu, c_op_slti, c_op_andi, c_op_ori, c_op_lw: begin
        w_ctrl.a_sel     = A_RS;
        w_ctrl.b_sel     = B_IMM;
        w_ctrl.reg_write = 1'b1;
        w_dst            = in_rt;
        if (in_opcode == c_op_slti) w_ctrl.alu_s = c_alu_lt;
        if (in_opcode == c_op_andi || in_opcode == c_op_ori) begin
          w_ctrl.alu_s = (in_opcode == c_op_andi) ? c_alu_and : c_alu_or;
          w_imm        = {{(DW-16){1'b0}}, in_imm};
        end
      end
      c_op_sw: begin
        w_ctrl.a_sel    = A_RS;
        w_ctrl.b_sel    = B_IMM;
        w_ctrl.store_en = 1'b1;
      end
      c_op_beq, c_op_bne: begin
        w_ctrl.alu_s = c_alu_eq;
        w_ctrl.a_sel = A_RS;
        w_ctrl.b_sel = B_RT;
      end
      default: w_ctrl.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_dst    <= '0;
      r_rs_val <= '0;
      r_rt_val <= '0;
      r_imm    <= '0;
    end else begin
      if (flush)          r_valid <= 1'b0;
      else if (w_capture) r_valid <= 1'b1;
      else if (out_ready) r_valid <= 1'b0;

      if (w_capture) begin
        r_ctrl   <= w_ctrl;
        r_rs     <= in_rs;
        r_rt     <= in_rt;
        r_dst    <= w_dst;
        r_imm    <= w_imm;
        r_rs_val <= w_rs_fwd;
        r_rt_val <= w_rt_fwd;
      end else if (w_hold) begin
        r_rs_val <= w_rs_fwd;
        r_rt_val <= w_rt_fwd;
      end
    end
  end

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    unique case (r_ctrl.a_sel)
      A_RS:    alu_a = r_rs_val;
      A_RT:    alu_a = r_rt_val;
      default: alu_a = '0;
    endcase
    unique case (r_ctrl.b_sel)
      B_RT:    alu_b = r_rt_val;
      B_IMM:   alu_b = r_imm;
      default: alu_b = '0;
    endcase
  end

  assign out_valid      = r_valid;
  assign alu_s          = r_ctrl.alu_s;
  assign out_store_data = r_ctrl.store_en ? r_rt_val : '0;
  assign out_dst        = r_dst;
  assign out_reg_write  = r_ctrl.reg_write;
  assign out_illegal    = r_ctrl.illegal;

endmodule

`default_nettype wire
